// File: rtl/iodelay_pkg.sv
// Shared types and constants for the IOLOGIC delay-tap controller.
//   state_t        : controller FSM states
//   DIR_INC/DIR_DEC: encodings driven on dly_direction
//   DEF_TAP_W/DEF_MAX_TAP: default tap counter geometry
//   cnt_width()    : width of the shared LOAD/SETTLE step timer
package iodelay_pkg;

   localparam int unsigned DEF_TAP_W   = 7;
   localparam int unsigned DEF_MAX_TAP = 127;

   localparam logic DIR_INC = 1'b0;
   localparam logic DIR_DEC = 1'b1;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_SETTLE,
      ST_DONE
   } state_t;

   // Bits needed to hold (max(a,b) - 1), never less than one.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/iodelay_step_timer.sv
// Loadable down-counter shared by the LOAD and SETTLE phases.
//   clk, rst    : clock, synchronous active-high reset
//   i_load      : load i_load_val this cycle (wins over counting)
//   i_load_val  : count value; the phase lasts i_load_val+1 cycles
//   o_zero_c    : combinational flag, counter has reached zero
module iodelay_step_timer
   import iodelay_pkg::*;
#(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero_c
);

   logic [CNT_W-1:0] r_count;

   // Count down to zero and hold there until reloaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/iodelay_tap_ctrl.sv
// Dynamic tap controller for the IOLOGIC delay element. Steps the delay
// from its current tap to a requested tap one MOVE pulse at a time, or
// reloads it to INIT_TAP via LOADN, and reports completion/abort.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake
//   req_load, req_tap       : reload request / target tap (clamped to MAX_TAP)
//   dly_loadn, dly_move,
//   dly_direction           : drive pins of the delay element
//   dly_cflag               : element reports range limit
//   cur_tap                 : tap currently applied
//   busy, done_pulse, err   : status; err qualifies done_pulse
module iodelay_tap_ctrl
   import iodelay_pkg::*;
#(
   parameter int unsigned TAP_W         = DEF_TAP_W,
   parameter int unsigned MAX_TAP       = DEF_MAX_TAP,
   parameter int unsigned INIT_TAP      = 0,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned LOAD_CYCLES   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_load,
   input  logic [TAP_W-1:0] req_tap,
   output logic             dly_loadn,
   output logic             dly_move,
   output logic             dly_direction,
   input  logic             dly_cflag,
   output logic [TAP_W-1:0] cur_tap,
   output logic             busy,
   output logic             done_pulse,
   output logic             err
);

   localparam int unsigned      CNT_W       = cnt_width(SETTLE_CYCLES, LOAD_CYCLES);
   localparam logic [TAP_W-1:0] MAX_TAP_V   = TAP_W'(MAX_TAP);
   localparam logic [TAP_W-1:0] INIT_TAP_V  = TAP_W'(INIT_TAP);
   localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           r_state;
   logic             r_auto_pend;
   logic [TAP_W-1:0] r_tgt;
   logic             r_req_ready;
   logic             r_dly_loadn;
   logic             r_dly_move;
   logic             r_dly_direction;
   logic [TAP_W-1:0] r_cur_tap;
   logic             r_busy;
   logic             r_done_pulse;
   logic             r_err;

   state_t           w_next_state;
   logic             w_next_err;
   logic             w_accept;
   logic [TAP_W-1:0] w_req_tgt;
   logic             w_tmr_load;
   logic [CNT_W-1:0] w_tmr_val;
   logic             w_tmr_zero;

   // Shared phase timer: reloaded on entry to LOAD or SETTLE.
   iodelay_step_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_zero_c   (w_tmr_zero)
   );

   // Next-state and completion-status decode.
   always_comb begin
      w_next_state = r_state;
      w_next_err   = 1'b0;
      w_accept     = 1'b0;
      w_req_tgt    = (req_tap > MAX_TAP_V) ? MAX_TAP_V : req_tap;

      unique case (r_state)
         ST_IDLE: begin
            // r_auto_pend is only set in the cycle right after reset.
            if (r_auto_pend) begin
               w_next_state = ST_LOAD;
            end else if (req_valid && r_req_ready) begin
               w_accept = 1'b1;
               if (req_load) begin
                  w_next_state = ST_LOAD;
               end else if (w_req_tgt == r_cur_tap) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_SETUP;
               end
            end
         end
         ST_LOAD: begin
            if (w_tmr_zero) begin
               w_next_state = r_auto_pend ? ST_IDLE : ST_DONE;
            end
         end
         ST_SETUP: begin
            w_next_state = ST_PULSE;
         end
         ST_PULSE: begin
            w_next_state = ST_SETTLE;
         end
         ST_SETTLE: begin
            // cflag only matters in the last settle cycle.
            if (w_tmr_zero) begin
               if (r_cur_tap == r_tgt) begin
                  w_next_state = ST_DONE;
               end else if (dly_cflag) begin
                  w_next_state = ST_DONE;
                  w_next_err   = 1'b1;
               end else begin
                  w_next_state = ST_SETUP;
               end
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign w_tmr_load = ((w_next_state == ST_LOAD)   && (r_state != ST_LOAD)) ||
                       ((w_next_state == ST_SETTLE) && (r_state != ST_SETTLE));
   assign w_tmr_val  = (w_next_state == ST_LOAD) ? LOAD_LAST : SETTLE_LAST;

   // State register plus outputs registered from the next state so that
   // every pin lines up with the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_auto_pend     <= 1'b1;
         r_tgt           <= INIT_TAP_V;
         r_req_ready     <= 1'b0;
         r_dly_loadn     <= 1'b1;
         r_dly_move      <= 1'b0;
         r_dly_direction <= DIR_INC;
         r_cur_tap       <= INIT_TAP_V;
         r_busy          <= 1'b0;
         r_done_pulse    <= 1'b0;
         r_err           <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_req_ready  <= (w_next_state == ST_IDLE);
         r_dly_loadn  <= (w_next_state != ST_LOAD);
         r_dly_move   <= (w_next_state == ST_PULSE);
         r_busy       <= (w_next_state != ST_IDLE);
         r_done_pulse <= (w_next_state == ST_DONE);
         r_err        <= w_next_err;

         if ((r_state == ST_LOAD) && w_tmr_zero) begin
            r_auto_pend <= 1'b0;
         end

         if (w_accept) begin
            r_tgt <= w_req_tgt;
         end

         // Direction only moves on the IDLE->SETUP edge, never alongside MOVE.
         if (w_accept && (w_next_state == ST_SETUP)) begin
            r_dly_direction <= (w_req_tgt < r_cur_tap) ? DIR_DEC : DIR_INC;
         end

         // Tap count follows the element: reset on load, step after each pulse.
         if ((w_next_state == ST_LOAD) && (r_state != ST_LOAD)) begin
            r_cur_tap <= INIT_TAP_V;
         end else if (r_state == ST_PULSE) begin
            r_cur_tap <= (r_dly_direction == DIR_DEC) ? (r_cur_tap - TAP_W'(1))
                                                      : (r_cur_tap + TAP_W'(1));
         end
      end
   end

   assign req_ready     = r_req_ready;
   assign dly_loadn     = r_dly_loadn;
   assign dly_move      = r_dly_move;
   assign dly_direction = r_dly_direction;
   assign cur_tap       = r_cur_tap;
   assign busy          = r_busy;
   assign done_pulse    = r_done_pulse;
   assign err           = r_err;

endmodule
